// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - RV32M divide issue sequencer driving an iterative divider
// Optional result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_issue_ctrl #(
  parameter int DIV_LATENCY_MAX = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_is_unsigned,
  input  logic        div_done,
  input  logic [31:0] div_val,
  input  logic [31:0] div_rem,
  output logic        stall,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        err
);

  localparam int CNT_W = $clog2(DIV_LATENCY_MAX + 1);

  typedef enum logic [2:0] {IDLE, START, WAIT, RESP, DRAIN} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               orphan;
  logic               op_rem;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               div_by_zero;
  logic               sgn_ovf;
  logic               special;
  logic [31:0]        special_res;
  logic               cnt_max;
  logic               wait_timeout;
  logic               cache_hit;
  logic [31:0]        cache_res;

  assign accept       = (state == IDLE) && valid && funct3[2];
  assign div_by_zero  = (rs2 == 32'h0);
  assign sgn_ovf      = !funct3[0] && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
  assign special      = div_by_zero || sgn_ovf;
  assign special_res  = div_by_zero ? (funct3[1] ? rs1 : 32'hFFFF_FFFF)
                                    : (funct3[1] ? 32'h0 : 32'h8000_0000);
  assign cnt_max      = (cnt == CNT_W'(DIV_LATENCY_MAX));
  assign wait_timeout = (state == WAIT) && !div_done && cnt_max;

`ifdef DIV_RESULT_CACHE_EN
  logic        cache_valid;
  logic        cache_uns;
  logic [31:0] cache_rs1;
  logic [31:0] cache_rs2;
  logic [31:0] cache_quo;
  logic [31:0] cache_rem;

  assign cache_hit = cache_valid && (rs1 == cache_rs1) && (rs2 == cache_rs2)
                     && (funct3[0] == cache_uns);
  assign cache_res = funct3[1] ? cache_rem : cache_quo;

  // Keyed on the latched operands, which are still stable in the done cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_valid <= 1'b0;
      cache_uns   <= 1'b0;
      cache_rs1   <= 32'h0;
      cache_rs2   <= 32'h0;
      cache_quo   <= 32'h0;
      cache_rem   <= 32'h0;
    end else if (wait_timeout) begin
      cache_valid <= 1'b0;
    end else if (state == WAIT && div_done) begin
      cache_valid <= 1'b1;
      cache_uns   <= div_is_unsigned;
      cache_rs1   <= div_dividend;
      cache_rs2   <= div_divisor;
      cache_quo   <= div_val;
      cache_rem   <= div_rem;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_res = 32'h0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (special || cache_hit) state_nxt = RESP;
          else if (orphan)          state_nxt = DRAIN;
          else                      state_nxt = START;
        end
      end
      START:   state_nxt = WAIT;
      WAIT:    if (div_done || cnt_max) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      DRAIN:   if (div_done || cnt_max) state_nxt = START;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall        = accept || (state == START) || (state == WAIT) || (state == DRAIN);
    div_start    = (state == START);
    result_valid = (state == RESP);
  end

  // A reset that lands mid-divide leaves the divider busy; orphan survives it
  // so the next op first absorbs the stale completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      orphan          <= (state == START) || (state == WAIT);
      cnt             <= '0;
      op_rem          <= 1'b0;
      div_dividend    <= 32'h0;
      div_divisor     <= 32'h0;
      div_is_unsigned <= 1'b0;
      result          <= 32'h0;
      err             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            div_dividend    <= rs1;
            div_divisor     <= rs2;
            div_is_unsigned <= funct3[0];
            op_rem          <= funct3[1];
            cnt             <= CNT_W'(1);
            if (special)        result <= special_res;
            else if (cache_hit) result <= cache_res;
          end
        end
        START: cnt <= CNT_W'(1);
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (div_done) begin
            result <= op_rem ? div_rem : div_val;
          end else if (cnt_max) begin
            err    <= 1'b1;
            result <= 32'h0;
          end
        end
        DRAIN: begin
          cnt <= cnt + CNT_W'(1);
          if (div_done || cnt_max) orphan <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
